// File: rtl/bakery_pkg.sv
// Shared definitions for the bakery front-panel menu.
// The state encoding is also used by the menu display decoder.
package bakery_pkg;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_SELECT  = 3'd1,
      ST_RELEASE = 3'd2,
      ST_START   = 3'd3,
      ST_RUN     = 3'd4,
      ST_DONE    = 3'd5
   } state_t;

   localparam int SCORE_W_DEFAULT = 3;
   localparam int BTN_W_DEFAULT   = 7;

endpackage

// File: rtl/bakery_menu_uc_edge_detector.sv
// Rising-edge detector for level inputs that are already synchronised.
// Produces a one-cycle high output on each 0->1 transition.
module edge_detector #(
   parameter int W = 1
) (
   input  logic         clock,
   input  logic         reset,
   input  logic [W-1:0] d,
   output logic [W-1:0] rise
);

   logic [W-1:0] d_q;
   logic [W-1:0] d_d;

   always_comb begin
      d_d = d;
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         d_q <= '0;
      end else begin
         d_q <= d_d;
      end
   end

   assign rise = d & ~d_q;

endmodule

// File: rtl/bakery_menu_uc.sv
// Front-panel scheduler: picks a game core, releases it from reset, pulses
// its start, routes the buttons to it and latches its final score.
module bakery_menu_uc
   import bakery_pkg::*;
#(
   parameter int N_GAMES   = 4,
   parameter int BTN_W     = BTN_W_DEFAULT,
   parameter int SCORE_W   = SCORE_W_DEFAULT,
   parameter int RUN_LIMIT = 50_000_000,
   localparam int SEL_W    = (N_GAMES > 1) ? $clog2(N_GAMES) : 1,
   localparam int CNT_W    = $clog2(RUN_LIMIT + 1)
) (
   input  logic                       clock,
   input  logic                       reset,
   input  logic                       jogar,
   input  logic [BTN_W-1:0]           botoes,
   input  logic [N_GAMES-1:0]         game_pronto,
   input  logic [N_GAMES*SCORE_W-1:0] game_pontuacao,
   output logic [N_GAMES-1:0]         game_reset,
   output logic [N_GAMES-1:0]         game_jogar,
   output logic [N_GAMES*BTN_W-1:0]   game_botoes,
   output logic [SEL_W-1:0]           selecao,
   output logic [2:0]                 estado,
   output logic [SCORE_W-1:0]         pontuacao,
   output logic                       pronto
);

   localparam logic [CNT_W-1:0] RUN_LIMIT_C = CNT_W'(RUN_LIMIT);

   state_t               state_q, state_d;
   logic [SEL_W-1:0]     selecao_q, selecao_d;
   logic [SCORE_W-1:0]   pontuacao_q, pontuacao_d;
   logic                 pronto_q, pronto_d;
   logic [CNT_W-1:0]     cnt_q, cnt_d;

   logic                 jogar_re;
   logic [N_GAMES-1:0]   btn_re;
   logic [SEL_W-1:0]     low_idx;
   logic                 sel_pronto;
   logic [SCORE_W-1:0]   sel_score;

   edge_detector #(.W(1)) u_jogar_edge (
      .clock (clock),
      .reset (reset),
      .d     (jogar),
      .rise  (jogar_re)
   );

   // Button bits at or above N_GAMES never select anything, so only the low slice is edge-detected.
   edge_detector #(.W(N_GAMES)) u_btn_edge (
      .clock (clock),
      .reset (reset),
      .d     (botoes[N_GAMES-1:0]),
      .rise  (btn_re)
   );

   always_comb begin
      low_idx    = '0;
      sel_pronto = 1'b0;
      sel_score  = '0;
      for (int k = N_GAMES - 1; k >= 0; k--) begin
         if (btn_re[k]) begin
            low_idx = SEL_W'(k);
         end
      end
      for (int k = 0; k < N_GAMES; k++) begin
         if (selecao_q == SEL_W'(k)) begin
            sel_pronto = game_pronto[k];
            sel_score  = game_pontuacao[k*SCORE_W +: SCORE_W];
         end
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q     <= ST_IDLE;
         selecao_q   <= '0;
         pontuacao_q <= '0;
         pronto_q    <= 1'b0;
         cnt_q       <= '0;
      end else begin
         state_q     <= state_d;
         selecao_q   <= selecao_d;
         pontuacao_q <= pontuacao_d;
         pronto_q    <= pronto_d;
         cnt_q       <= cnt_d;
      end
   end

   // In SELECT a confirm edge takes priority over a simultaneous button edge.
   always_comb begin
      state_d     = state_q;
      selecao_d   = selecao_q;
      pontuacao_d = pontuacao_q;
      cnt_d       = cnt_q;
      case (state_q)
         ST_IDLE: begin
            if (jogar_re) state_d = ST_SELECT;
         end
         ST_SELECT: begin
            if (jogar_re) begin
               state_d = ST_RELEASE;
            end else if (|btn_re) begin
               selecao_d = low_idx;
            end
         end
         ST_RELEASE: state_d = ST_START;
         ST_START: begin
            cnt_d   = '0;
            state_d = ST_RUN;
         end
         ST_RUN: begin
            if (cnt_q != RUN_LIMIT_C) cnt_d = cnt_q + CNT_W'(1);
            if (sel_pronto) begin
               pontuacao_d = sel_score;
               state_d     = ST_DONE;
            end else if (cnt_q == RUN_LIMIT_C) begin
               pontuacao_d = '0;
               state_d     = ST_DONE;
            end
         end
         ST_DONE: begin
            if (jogar_re) state_d = ST_SELECT;
         end
         default: state_d = ST_IDLE;
      endcase
      pronto_d = (state_d == ST_DONE);
   end

   // Reset and start decode only from registers so they cannot glitch on input changes.
   always_comb begin
      game_reset  = '1;
      game_jogar  = '0;
      game_botoes = '0;
      for (int k = 0; k < N_GAMES; k++) begin
         if (selecao_q == SEL_W'(k)) begin
            if (state_q == ST_RELEASE || state_q == ST_START ||
                state_q == ST_RUN || state_q == ST_DONE) begin
               game_reset[k] = 1'b0;
            end
            if (state_q == ST_START) game_jogar[k] = 1'b1;
            if (state_q == ST_RUN) game_botoes[k*BTN_W +: BTN_W] = botoes;
         end
      end
   end

   assign selecao   = selecao_q;
   assign estado    = state_q;
   assign pontuacao = pontuacao_q;
   assign pronto    = pronto_q;

endmodule

// File: tb/tb_bakery_menu_uc.sv
// Directed self-checking bench for bakery_menu_uc with four cores and a short run limit.
module tb_bakery_menu_uc;

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic        jogar = 1'b0;
   logic [6:0]  botoes = '0;
   logic [3:0]  game_pronto = '0;
   logic [11:0] game_pontuacao = '0;
   logic [3:0]  game_reset;
   logic [3:0]  game_jogar;
   logic [27:0] game_botoes;
   logic [1:0]  selecao;
   logic [2:0]  estado;
   logic [2:0]  pontuacao;
   logic        pronto;

   int checks = 0;
   int errors = 0;

   bakery_menu_uc #(
      .N_GAMES   (4),
      .BTN_W     (7),
      .SCORE_W   (3),
      .RUN_LIMIT (10)
   ) dut (
      .clock          (clock),
      .reset          (reset),
      .jogar          (jogar),
      .botoes         (botoes),
      .game_pronto    (game_pronto),
      .game_pontuacao (game_pontuacao),
      .game_reset     (game_reset),
      .game_jogar     (game_jogar),
      .game_botoes    (game_botoes),
      .selecao        (selecao),
      .estado         (estado),
      .pontuacao      (pontuacao),
      .pronto         (pronto)
   );

   always #5 clock = ~clock;

   // Advance one clock and settle just past the rising edge.
   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic test_reset();
      #1 reset = 1'b0;
      #2;
      checks++; if (estado !== 3'd0) begin errors++; $display("[TB] FAIL reset_estado got %0d exp 0", estado); end
      checks++; if (game_reset !== 4'b1111) begin errors++; $display("[TB] FAIL reset_game_reset got %b exp 1111", game_reset); end
      checks++; if ({game_jogar, game_botoes, selecao, pontuacao, pronto} !== '0) begin errors++; $display("[TB] FAIL reset_outputs got %h exp 0", {game_jogar, game_botoes, selecao, pontuacao, pronto}); end
      tick();
      reset = 1'b1;
      tick();
      checks++; if (estado !== 3'd0) begin errors++; $display("[TB] FAIL idle_hold got %0d exp 0", estado); end
   endtask

   task automatic test_launch();
      jogar = 1'b1; tick();
      checks++; if (estado !== 3'd1) begin errors++; $display("[TB] FAIL enter_select got %0d exp 1", estado); end
      checks++; if (game_reset !== 4'b1111) begin errors++; $display("[TB] FAIL select_reset got %b exp 1111", game_reset); end
      jogar = 1'b0; tick();
      botoes = 7'b0000100; tick();
      checks++; if (selecao !== 2'd2) begin errors++; $display("[TB] FAIL select_core2 got %0d exp 2", selecao); end
      botoes = '0; jogar = 1'b1; tick();
      checks++; if (estado !== 3'd2 || game_reset !== 4'b1011 || game_jogar !== 4'b0000) begin errors++; $display("[TB] FAIL release got st=%0d rst=%b go=%b exp st=2 rst=1011 go=0000", estado, game_reset, game_jogar); end
      jogar = 1'b0; tick();
      checks++; if (estado !== 3'd3 || game_reset !== 4'b1011 || game_jogar !== 4'b0100) begin errors++; $display("[TB] FAIL start got st=%0d rst=%b go=%b exp st=3 rst=1011 go=0100", estado, game_reset, game_jogar); end
      tick();
      checks++; if (estado !== 3'd4 || game_jogar !== 4'b0000) begin errors++; $display("[TB] FAIL run_entry got st=%0d go=%b exp st=4 go=0000", estado, game_jogar); end
   endtask

   task automatic test_routing_score();
      botoes = 7'b1010101; #1;
      checks++; if (game_botoes !== {7'b0, 7'b1010101, 14'b0}) begin errors++; $display("[TB] FAIL routing got %h exp %h", game_botoes, {7'b0, 7'b1010101, 14'b0}); end
      game_pronto = 4'b0001; game_pontuacao = 12'b000_000_000_111; tick();
      checks++; if (estado !== 3'd4 || pronto !== 1'b0) begin errors++; $display("[TB] FAIL unselected_pronto got st=%0d pronto=%b exp st=4 pronto=0", estado, pronto); end
      game_pronto = 4'b0100; game_pontuacao = {3'd0, 3'd5, 3'd0, 3'd0}; tick();
      checks++; if (pronto !== 1'b1 || pontuacao !== 3'd5 || estado !== 3'd5) begin errors++; $display("[TB] FAIL score got pronto=%b pts=%0d st=%0d exp 1 5 5", pronto, pontuacao, estado); end
      checks++; if (game_botoes !== '0 || game_reset !== 4'b1011) begin errors++; $display("[TB] FAIL done_outputs got btn=%h rst=%b exp btn=0 rst=1011", game_botoes, game_reset); end
      game_pronto = '0; game_pontuacao = '0; botoes = '0;
   endtask

   task automatic test_replay();
      jogar = 1'b1; tick();
      checks++; if (estado !== 3'd1 || pronto !== 1'b0 || game_reset !== 4'b1111) begin errors++; $display("[TB] FAIL replay got st=%0d pronto=%b rst=%b exp 1 0 1111", estado, pronto, game_reset); end
      checks++; if (selecao !== 2'd2 || pontuacao !== 3'd5) begin errors++; $display("[TB] FAIL replay_kept got sel=%0d pts=%0d exp 2 5", selecao, pontuacao); end
      jogar = 1'b0; tick();
   endtask

   task automatic test_simultaneous();
      botoes = 7'b0000011; tick();
      checks++; if (selecao !== 2'd0) begin errors++; $display("[TB] FAIL lowest_wins got %0d exp 0", selecao); end
      botoes = '0; tick();
      botoes = 7'b1110000; tick();
      checks++; if (selecao !== 2'd0 || estado !== 3'd1) begin errors++; $display("[TB] FAIL high_bits_ignored got sel=%0d st=%0d exp 0 1", selecao, estado); end
      botoes = 7'b0000010; jogar = 1'b1; tick();
      checks++; if (estado !== 3'd2 || selecao !== 2'd0) begin errors++; $display("[TB] FAIL jogar_priority got st=%0d sel=%0d exp 2 0", estado, selecao); end
      botoes = '0; jogar = 1'b0; tick();
      checks++; if (game_jogar !== 4'b0001) begin errors++; $display("[TB] FAIL relaunch_pulse got %b exp 0001", game_jogar); end
      tick();
   endtask

   task automatic test_timeout();
      for (int i = 0; i < 10; i++) tick();
      checks++; if (estado !== 3'd4) begin errors++; $display("[TB] FAIL timeout_early got %0d exp 4", estado); end
      tick();
      checks++; if (estado !== 3'd5 || pontuacao !== 3'd0 || pronto !== 1'b1) begin errors++; $display("[TB] FAIL timeout got st=%0d pts=%0d pronto=%b exp 5 0 1", estado, pontuacao, pronto); end
   endtask

   task automatic test_pronto_on_limit();
      jogar = 1'b1; tick();
      jogar = 1'b0; botoes = 7'b0000010; tick();
      botoes = '0; jogar = 1'b1; tick();
      jogar = 1'b0; tick();
      tick();
      checks++; if (estado !== 3'd4 || selecao !== 2'd1) begin errors++; $display("[TB] FAIL limit_run got st=%0d sel=%0d exp 4 1", estado, selecao); end
      for (int i = 0; i < 10; i++) tick();
      game_pronto = 4'b0010; game_pontuacao = {3'd0, 3'd0, 3'd3, 3'd0}; tick();
      checks++; if (estado !== 3'd5 || pontuacao !== 3'd3) begin errors++; $display("[TB] FAIL pronto_on_limit got st=%0d pts=%0d exp 5 3", estado, pontuacao); end
      game_pronto = '0; game_pontuacao = '0;
   endtask

   task automatic test_reset_mid_run();
      jogar = 1'b1; tick();
      jogar = 1'b0; botoes = 7'b0000100; tick();
      botoes = '0; jogar = 1'b1; tick();
      jogar = 1'b0; tick();
      tick();
      botoes = 7'b1111111; #1;
      checks++; if (estado !== 3'd4 || game_botoes !== {7'b0, 7'b1111111, 14'b0}) begin errors++; $display("[TB] FAIL pre_reset got st=%0d btn=%h", estado, game_botoes); end
      reset = 1'b0; #1;
      checks++; if (estado !== 3'd0 || game_reset !== 4'b1111) begin errors++; $display("[TB] FAIL async_reset got st=%0d rst=%b exp 0 1111", estado, game_reset); end
      checks++; if ({game_jogar, game_botoes, selecao, pontuacao, pronto} !== '0) begin errors++; $display("[TB] FAIL async_reset_outputs got %h exp 0", {game_jogar, game_botoes, selecao, pontuacao, pronto}); end
      botoes = '0; tick();
      reset = 1'b1; tick();
   endtask

   initial begin
      test_reset();
      test_launch();
      test_routing_score();
      test_replay();
      test_simultaneous();
      test_timeout();
      test_pronto_on_limit();
      test_reset_mid_run();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
